// File: rtl/eth_axis_fcs_pad.sv
// eth_axis_fcs_pad: byte-wide AXI4-Stream stage that pads short Ethernet
// frames with zero bytes and appends a 4-byte IEEE 802.3 CRC-32 FCS.
// Build option: define ETH_FCS_PAD_EN to enable padding up to
// MIN_FRAME_LENGTH-4 bytes. Without it, every frame gets the FCS appended
// directly and MIN_FRAME_LENGTH only takes part in the configuration check.
// Output is a main+temp skid pair, so the input ready can be registered.
module eth_axis_fcs_pad #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int CNT_WIDTH        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy
);

  // The pad target has to fit in the byte counter.
  if (MIN_FRAME_LENGTH < 5 || (MIN_FRAME_LENGTH - 4) >= (1 << CNT_WIDTH)) begin : g_bad_cfg
    $error("eth_axis_fcs_pad: MIN_FRAME_LENGTH-4 must be >= 1 and fit in CNT_WIDTH bits");
  end

  typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, FCS} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
`ifdef ETH_FCS_PAD_EN
  localparam logic [CNT_WIDTH-1:0] PAD_TARGET = CNT_WIDTH'(MIN_FRAME_LENGTH - 4);
`endif

  state_t               state, state_next;
  logic [31:0]          crc, crc_next, crc_base, fcs_word;
  logic [CNT_WIDTH-1:0] count, count_next, count_base, count_inc;
  logic [1:0]           fcs_idx, fcs_idx_next;
  logic                 user_lat, user_lat_next;
  logic                 s_ready_reg, s_ready_next;

  // beat handed from the framing logic to the skid stage
  logic [7:0] int_data;
  logic       int_valid, int_last, int_user;
  logic       int_ready, int_ready_early;

  // skid storage
  logic [7:0] out_data, temp_data;
  logic       out_valid, out_last, out_user;
  logic       temp_valid, temp_last, temp_user;

  // Reflected CRC-32 (0xEDB88320), one byte folded in LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign s_axis_tready   = s_ready_reg;
  assign m_axis_tdata    = out_data;
  assign m_axis_tvalid   = out_valid;
  assign m_axis_tlast    = out_last;
  assign m_axis_tuser    = out_user;
  assign busy            = (state != IDLE);
  assign fcs_word        = ~crc;
  assign int_ready_early = m_axis_tready || (!temp_valid && !out_valid);

  // A new frame always starts from a fresh CRC and a zero count.
  assign crc_base   = (state == IDLE) ? 32'hFFFFFFFF : crc;
  assign count_base = (state == IDLE) ? '0 : count;
  assign count_inc  = (count_base == CNT_MAX) ? count_base : count_base + CNT_WIDTH'(1);

  // Framing FSM: next state, CRC/count updates and the beat for the skid stage.
  always_comb begin
    state_next    = state;
    crc_next      = crc;
    count_next    = count;
    fcs_idx_next  = fcs_idx;
    user_lat_next = user_lat;
    s_ready_next  = 1'b0;
    int_data      = s_axis_tdata;
    int_valid     = 1'b0;
    int_last      = 1'b0;
    int_user      = 1'b0;
    case (state)
      IDLE, PAYLOAD: begin
        s_ready_next = int_ready_early;
        if (s_axis_tvalid && s_ready_reg) begin
          int_valid  = 1'b1;
          crc_next   = crc_byte(crc_base, s_axis_tdata);
          count_next = count_inc;
          state_next = PAYLOAD;
          if (s_axis_tlast) begin
            user_lat_next = s_axis_tuser;
            s_ready_next  = 1'b0;
            fcs_idx_next  = 2'd0;
`ifdef ETH_FCS_PAD_EN
            state_next    = (count_inc < PAD_TARGET) ? PAD : FCS;
`else
            state_next    = FCS;
`endif
          end
        end
      end
`ifdef ETH_FCS_PAD_EN
      PAD: begin
        int_data = 8'h00;
        if (int_ready) begin
          int_valid  = 1'b1;
          crc_next   = crc_byte(crc, 8'h00);
          count_next = count_inc;
          if (count_inc >= PAD_TARGET) state_next = FCS;
        end
      end
`endif
      FCS: begin
        int_data = fcs_word[{fcs_idx, 3'b000} +: 8];
        int_last = (fcs_idx == 2'd3);
        int_user = (fcs_idx == 2'd3) && user_lat;
        if (int_ready) begin
          int_valid    = 1'b1;
          fcs_idx_next = fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state_next   = IDLE;
            s_ready_next = int_ready_early;
            crc_next     = 32'hFFFFFFFF;
            count_next   = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Framing state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      crc         <= 32'hFFFFFFFF;
      count       <= '0;
      fcs_idx     <= 2'd0;
      user_lat    <= 1'b0;
      s_ready_reg <= 1'b0;
    end else begin
      state       <= state_next;
      crc         <= crc_next;
      count       <= count_next;
      fcs_idx     <= fcs_idx_next;
      user_lat    <= user_lat_next;
      s_ready_reg <= s_ready_next;
    end
  end

  // Skid output: new beats go straight out when possible, otherwise park in
  // temp; temp drains to the output as soon as downstream takes a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_ready  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      out_user   <= 1'b0;
      temp_valid <= 1'b0;
      temp_data  <= 8'h00;
      temp_last  <= 1'b0;
      temp_user  <= 1'b0;
    end else begin
      int_ready <= int_ready_early;
      if (int_ready) begin
        if (m_axis_tready || !out_valid) begin
          out_valid <= int_valid;
          out_data  <= int_data;
          out_last  <= int_last;
          out_user  <= int_user;
        end else begin
          temp_valid <= int_valid;
          temp_data  <= int_data;
          temp_last  <= int_last;
          temp_user  <= int_user;
        end
      end else if (m_axis_tready) begin
        out_valid  <= temp_valid;
        out_data   <= temp_data;
        out_last   <= temp_last;
        out_user   <= temp_user;
        temp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_axis_fcs_pad.sv
// Self-checking bench for eth_axis_fcs_pad. Expected streams come from a
// table-driven CRC-32 reference and the framing rules (pad to 60 bytes when
// ETH_FCS_PAD_EN is defined, FCS LSB byte first, tlast/tuser on the last FCS byte).
module tb_eth_axis_fcs_pad;
  localparam int MIN_LEN = 64;
  localparam int CW      = 8;   // small counter so long frames reach saturation

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       m_axis_tready = 1'b1;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] crc_tab [256];
  logic [7:0]  ref9 [4];
  logic [7:0]  frm [$];
  logic [9:0]  exp_q [$];   // {data, last, user}
  logic [9:0]  cap_q [$];

  eth_axis_fcs_pad #(.MIN_FRAME_LENGTH(MIN_LEN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference stream for the frame in frm.
  task automatic build_exp(input logic usr);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    exp_q.delete();
    c = 32'hFFFFFFFF;
    n = frm.size();
`ifdef ETH_FCS_PAD_EN
    if (n < MIN_LEN - 4) n = MIN_LEN - 4;
`endif
    for (int i = 0; i < n; i++) begin
      b = (i < frm.size()) ? frm[i] : 8'h00;
      c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
      exp_q.push_back({b, 2'b00});
    end
    c = ~c;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({c[8*k +: 8], (k == 3) ? 1'b1 : 1'b0, (k == 3) ? usr : 1'b0});
  endtask

  // Present one byte and hold it until it is accepted (bounded).
  task automatic send_byte(input logic [7:0] d, input logic l, input logic u, output bit ok);
    bit acc;
    int g;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u;
    acc = 1'b0; g = 0;
    while (!acc && g < 5000) begin
      @(negedge clk); acc = s_axis_tready;
      @(posedge clk); #1; g++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    ok = acc;
  endtask

  // Drive frm, collect the output stream and compare it beat by beat.
  task automatic run_frame(input string tag, input logic usr, input bit rnd);
    int got, limit;
    bit done, stuck;
    build_exp(usr);
    cap_q.delete();
    got = 0; done = 1'b0; stuck = 1'b0;
    limit = 20 * exp_q.size() + 200;
    m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    fork
      begin
        bit ok;
        for (int i = 0; i < frm.size(); i++) begin
          while (rnd && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_byte(frm[i], (i == frm.size() - 1),
                    (i == frm.size() - 1) ? usr : (rnd ? 1'($urandom_range(0, 1)) : 1'b0), ok);
          if (!ok) begin stuck = 1'b1; break; end
        end
      end
      begin
        int cyc;
        bit stalled;
        logic [9:0] prev;
        cyc = 0; stalled = 1'b0; prev = '0;
        while (!done && cyc < limit) begin
          @(negedge clk);
          if (stalled)
            chk({tag, "_hold"}, 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                32'({1'b1, prev}));
          if (m_axis_tvalid && m_axis_tready) begin
            cap_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            if (got < exp_q.size())
              chk({tag, "_beat"}, 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'(exp_q[got]));
            got++;
            if (m_axis_tlast) done = 1'b1;
          end
          stalled = m_axis_tvalid && !m_axis_tready;
          prev    = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
          @(posedge clk); #1;
          m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          cyc++;
        end
      end
    join
    m_axis_tready = 1'b1;
    chk({tag, "_input_accepted"}, 32'(stuck), 32'(0));
    chk({tag, "_beats"}, 32'(got), 32'(exp_q.size()));
    chk({tag, "_busy_after"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic [31:0] v;
    bit ok;
    int len;
    for (int i = 0; i < 256; i++) begin
      v = 32'(i);
      for (int j = 0; j < 8; j++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tab[i] = v;
    end
    ref9[0] = 8'h26; ref9[1] = 8'h39; ref9[2] = 8'hF4; ref9[3] = 8'hCB;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 32'(s_axis_tready), 32'(0));
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("rst_m_tlast",  32'(m_axis_tlast),  32'(0));
    chk("rst_m_tuser",  32'(m_axis_tuser),  32'(0));
    chk("rst_busy",     32'(busy),          32'(0));
    @(posedge clk); #1; rst = 1'b0;

`ifndef ETH_FCS_PAD_EN
    // "123456789" -> check value 0xCBF43926 sent LSB first, no padding
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    run_frame("crc9", 1'b0, 1'b0);
    chk("crc9_len", 32'(cap_q.size()), 32'(13));
    if (cap_q.size() == 13)
      for (int k = 0; k < 4; k++) chk("crc9_fcs", 32'(cap_q[9+k][9:2]), 32'(ref9[k]));
`else
    // single byte -> 59 pad bytes + FCS
    frm.delete(); frm.push_back(8'hAA);
    run_frame("one_byte", 1'b0, 1'b0);
    chk("one_byte_len", 32'(cap_q.size()), 32'(64));
`endif

    // exactly 60 bytes: no pad either way
    frm.delete();
    for (int i = 0; i < 60; i++) frm.push_back(8'(i));
    run_frame("len60", 1'b0, 1'b0);
    chk("len60_len", 32'(cap_q.size()), 32'(64));

    frm.delete();
    for (int i = 0; i < 100; i++) frm.push_back(8'($urandom));
    run_frame("len100", 1'b0, 1'b0);
    chk("len100_len", 32'(cap_q.size()), 32'(104));

    // bad-frame marker on a 70-byte frame, then a clean frame
    frm.delete();
    for (int i = 0; i < 70; i++) frm.push_back(8'($urandom));
    run_frame("tuser", 1'b1, 1'b0);
    chk("tuser_beat74", 32'((cap_q.size() > 73) ? cap_q[73][0] : 1'b0), 32'(1));
    frm.delete();
    for (int i = 0; i < 20; i++) frm.push_back(8'($urandom));
    run_frame("after_tuser", 1'b0, 1'b0);

    // longer than the counter range: count saturates, CRC keeps going
    frm.delete();
    for (int i = 0; i < 300; i++) frm.push_back(8'($urandom));
    run_frame("long", 1'b0, 1'b0);

    // reset in the middle of a payload
    frm.delete();
    for (int i = 0; i < 30; i++) frm.push_back(8'($urandom));
    send_byte(frm[0], 1'b0, 1'b0, ok);
    @(negedge clk);
    chk("latency_valid", 32'(m_axis_tvalid), 32'(1));
    chk("latency_data",  32'(m_axis_tdata),  32'(frm[0]));
    @(posedge clk); #1;
    for (int i = 1; i < 20 && ok; i++) send_byte(frm[i], 1'b0, 1'b0, ok);
    chk("mid_drv", 32'(ok), 32'(1));
    chk("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("mid_rst_busy",     32'(busy),          32'(0));
    chk("mid_rst_s_tready", 32'(s_axis_tready), 32'(0));
    @(posedge clk); #1;
    frm.delete();
    for (int i = 0; i < 64; i++) frm.push_back(8'($urandom));
    run_frame("post_rst", 1'b0, 1'b0);

    // random back-pressure and input gaps
    for (int f = 0; f < 200; f++) begin
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(61, 1518)) : int'($urandom_range(1, 100));
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      run_frame("rnd", 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
